// File: rtl/vector_lsu_pkg.sv
// Shared types and sizing for the vector load/store sequencer.
// Pure declarations; no logic, latency or flow control.
package vector_lsu_pkg;

    localparam int LANES_DEF = 8;
    localparam int VEC_W     = 256;
    localparam int LANE_W    = VEC_W / LANES_DEF;
    localparam int IDX_W     = $clog2(LANES_DEF);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_LAST,
        STORE,
        DONE
    } lsu_state_e;

endpackage

// File: rtl/vector_lsu_addr_gen.sv
// Strided element address accumulator with lane counter and last-lane flag.
// Outputs are registered and update one cycle after load/step; there is no backpressure.
module vector_lsu_addr_gen
    import vector_lsu_pkg::*;
#(
    parameter int N     = 24,
    parameter int LANES = LANES_DEF,
    parameter int CNT_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [N-1:0]     base,
    input  logic [N-1:0]     stride,
    output logic [N-1:0]     addr,
    output logic [CNT_W-1:0] idx,
    output logic             last
);

    logic [N-1:0]     addr_q,   addr_d;
    logic [N-1:0]     stride_q, stride_d;
    logic [CNT_W-1:0] idx_q,    idx_d;

    // Stride is captured with the base so later changes on the input are harmless.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        idx_d    = idx_q;
        if (load) begin
            addr_d   = base;
            stride_d = stride;
            idx_d    = '0;
        end else if (step) begin
            addr_d = addr_q + stride_q;
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            idx_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            idx_q    <= idx_d;
        end
    end

    assign addr = addr_q;
    assign idx  = idx_q;
    assign last = (idx_q == CNT_W'(LANES - 1));

endmodule

// File: rtl/vector_lsu.sv
// Sequences one vector load/store as LANES strided scalar RAM accesses, packing/unpacking 32-bit slots.
// Load: LANES+2 cycles start-to-done, store: LANES+1; pipeline stalled while active, start ignored unless IDLE.
module vector_lsu
    import vector_lsu_pkg::*;
#(
    parameter int N     = 24,
    parameter int LANES = LANES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_store,
    input  logic [N-1:0]     base_address,
    input  logic [N-1:0]     stride,
    input  logic [VEC_W-1:0] store_vector,
    input  logic [N-1:0]     mem_read_data,
    output logic [N-1:0]     mem_address,
    output logic [N-1:0]     mem_write_data,
    output logic             mem_wren,
    output logic [VEC_W-1:0] load_vector,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int SLOT_W = VEC_W / LANES;
    localparam int CNT_W  = $clog2(LANES);

    lsu_state_e                state_q, state_d;
    logic [LANES-1:0][N-1:0]   store_lanes_q, store_lanes_d;
    logic [VEC_W-1:0]          load_vec_q, load_vec_d;

    logic             ag_load, ag_step, ag_last;
    logic [N-1:0]     ag_addr;
    logic [CNT_W-1:0] ag_idx;
    logic             cap_en;
    logic [CNT_W-1:0] cap_lane;
    logic             unused_store_hi;

    vector_lsu_addr_gen #(
        .N     (N),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (ag_load),
        .step   (ag_step),
        .base   (base_address),
        .stride (stride),
        .addr   (ag_addr),
        .idx    (ag_idx),
        .last   (ag_last)
    );

    // Read data trails the issued address by one cycle, so lane idx-1 is captured.
    always_comb begin
        state_d       = state_q;
        store_lanes_d = store_lanes_q;
        load_vec_d    = load_vec_q;
        ag_load       = 1'b0;
        ag_step       = 1'b0;
        cap_en        = 1'b0;
        cap_lane      = ag_idx - 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ag_load = 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        store_lanes_d[i] = store_vector[i*SLOT_W +: N];
                    end
                    state_d = is_store ? STORE : LOAD;
                end
            end
            LOAD: begin
                ag_step = 1'b1;
                cap_en  = (ag_idx != '0);
                if (ag_last) state_d = LOAD_LAST;
            end
            LOAD_LAST: begin
                cap_en   = 1'b1;
                cap_lane = CNT_W'(LANES - 1);
                state_d  = DONE;
            end
            STORE: begin
                ag_step = 1'b1;
                if (ag_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cap_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (cap_lane == CNT_W'(i)) begin
                    load_vec_d[i*SLOT_W +: SLOT_W] = SLOT_W'(mem_read_data);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            store_lanes_q <= '0;
            load_vec_q    <= '0;
        end else begin
            state_q       <= state_d;
            store_lanes_q <= store_lanes_d;
            load_vec_q    <= load_vec_d;
        end
    end

    // Upper slot bits of the store operand are intentionally dropped.
    assign unused_store_hi = ^store_vector;

    assign mem_address    = (state_q == LOAD || state_q == STORE) ? ag_addr : '0;
    assign mem_write_data = (state_q == STORE) ? store_lanes_q[ag_idx] : '0;
    assign mem_wren       = (state_q == STORE);
    assign load_vector    = load_vec_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign stall          = ((state_q == IDLE) && start) ||
                            (state_q == LOAD) || (state_q == LOAD_LAST) || (state_q == STORE);

endmodule
